// File: rtl/fp_addsub_ctrl_if.sv
// ---------------------------------------------------------------------------
// fp_addsub_ctrl_if
// Handshake/data bundle between a requester and the fp_addsub_ctrl
// sequential single-precision adder/subtractor.
//   start  : request, sampled by the core only while it is idle
//   op     : 0 = a+b, 1 = a-b
//   a, b   : IEEE-754 single-precision operands
//   busy   : core is working (every state except IDLE)
//   done   : one-cycle pulse, result is valid
//   result : packed sum/difference, held until the next done
// Modports: master (requester side), slave (the arithmetic core).
// ---------------------------------------------------------------------------
interface fp_addsub_ctrl_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/fp_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// fp_addsub_ctrl
// Multi-cycle IEEE-754 single-precision add/subtract controller.
// Sequence: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
// Truncating arithmetic, no NaN/infinity detection, denormals read as zero,
// underflow during normalisation flushes to +0, exponent >= 255 packs as
// a signed infinity pattern.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    fp_addsub_ctrl_if.slave (start/op/a/b in, busy/done/result out)
//
// Build option:
//   FP_ADDSUB_FAST_ALIGN_EN  defined   -> ALIGN barrel-shifts in one cycle
//                            undefined -> ALIGN shifts one bit per cycle
//   Results are bit-identical in both builds; only latency differs.
// ---------------------------------------------------------------------------
module fp_addsub_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    fp_addsub_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        signL_q, signL_d;
    logic        signS_q, signS_d;
    logic [23:0] mantL_q, mantL_d;
    logic [23:0] mantS_q, mantS_d;
    logic [23:0] mantR_q, mantR_d;
    logic [8:0]  exp_q,   exp_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [31:0] result_q, result_d;

    // Operand decode at capture time: exponent 0 is treated as zero, and the
    // effective sign of b folds in the subtract request.
    logic [7:0]  expA, expB, expL, expS, expDiff;
    logic [23:0] mantA, mantB;
    logic        signA, signB, aIsL;
    logic [24:0] sumW, diffW;

    assign expA  = bus.a[30:23];
    assign expB  = bus.b[30:23];
    assign mantA = (expA == 8'd0) ? 24'd0 : {1'b1, bus.a[22:0]};
    assign mantB = (expB == 8'd0) ? 24'd0 : {1'b1, bus.b[22:0]};
    assign signA = bus.a[31];
    assign signB = bus.b[31] ^ bus.op;

    // Magnitude compare: exponent first, then mantissa; a wins a tie.
    assign aIsL    = (expA > expB) || ((expA == expB) && (mantA >= mantB));
    assign expL    = aIsL ? expA : expB;
    assign expS    = aIsL ? expB : expA;
    assign expDiff = expL - expS;

    // Both candidate ADD results; L >= S in magnitude so the difference never wraps.
    assign sumW  = {1'b0, mantL_q} + {1'b0, mantS_q};
    assign diffW = {1'b0, mantL_q} - {1'b0, mantS_q};

    // Next-state logic for the whole datapath and the registered outputs.
    always_comb begin
        state_d  = state_q;
        signL_d  = signL_q;
        signS_d  = signS_q;
        mantL_d  = mantL_q;
        mantS_d  = mantS_q;
        mantR_d  = mantR_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    signL_d = aIsL ? signA : signB;
                    signS_d = aIsL ? signB : signA;
                    mantL_d = aIsL ? mantA : mantB;
                    mantS_d = aIsL ? mantB : mantA;
                    mantR_d = 24'd0;
                    exp_d   = {1'b0, expL};
                    // Shifting past 25 bits gives the same (zero) contribution.
                    cnt_d   = (expDiff > 8'd25) ? 5'd25 : expDiff[4:0];
                    state_d = ALIGN;
                end
            end

            ALIGN: begin
`ifdef FP_ADDSUB_FAST_ALIGN_EN
                mantS_d = mantS_q >> cnt_q;
                cnt_d   = 5'd0;
                state_d = ADD;
`else
                if (cnt_q != 5'd0) begin
                    mantS_d = mantS_q >> 1;
                    cnt_d   = cnt_q - 5'd1;
                end else begin
                    state_d = ADD;
                end
`endif
            end

            ADD: begin
                if (signL_q == signS_q) begin
                    // Carry out renormalises right by one immediately.
                    if (sumW[24]) begin
                        mantR_d = sumW[24:1];
                        exp_d   = exp_q + 9'd1;
                    end else begin
                        mantR_d = sumW[23:0];
                    end
                end else begin
                    mantR_d = diffW[23:0];
                end
                state_d = NORM;
            end

            NORM: begin
                if (mantR_q == 24'd0) begin
                    result_d = 32'h0000_0000;
                    state_d  = DONE;
                end else if (mantR_q[23]) begin
                    if (exp_q >= 9'd255)
                        result_d = {signL_q, 8'hFF, 23'd0};
                    else
                        result_d = {signL_q, exp_q[7:0], mantR_q[22:0]};
                    state_d = DONE;
                end else if (exp_q <= 9'd1) begin
                    // Another left shift would reach exponent 0: flush to +0.
                    result_d = 32'h0000_0000;
                    state_d  = DONE;
                end else begin
                    mantR_d = mantR_q << 1;
                    exp_d   = exp_q - 9'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Single state register for the FSM and datapath; reset discards any
    // partial operation and clears the visible outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            signL_q  <= 1'b0;
            signS_q  <= 1'b0;
            mantL_q  <= 24'd0;
            mantS_q  <= 24'd0;
            mantR_q  <= 24'd0;
            exp_q    <= 9'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            signL_q  <= signL_d;
            signS_q  <= signS_d;
            mantL_q  <= mantL_d;
            mantS_q  <= mantS_d;
            mantR_q  <= mantR_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_ctrl
// Directed bench for fp_addsub_ctrl: hand-computed operand/result vectors,
// latency and busy-length checks, mid-operation reset and held-start cases.
// Expected latencies follow the FP_ADDSUB_FAST_ALIGN_EN build option.
// ---------------------------------------------------------------------------
module tb_fp_addsub_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fp_addsub_ctrl_if bus ();

    fp_addsub_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Expected number of edges from start sample to done visible.
    function automatic int expLat(input int alignN, input int normN);
`ifdef FP_ADDSUB_FAST_ALIGN_EN
        return 4 + normN;
`else
        return 4 + alignN + normN;
`endif
    endfunction

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation, wait (bounded) for done, then check result,
    // latency, busy length and the return to idle.
    task automatic applyStimulus(input string tag, input logic [31:0] aVal,
                                 input logic [31:0] bVal, input logic opVal,
                                 input logic [31:0] expRes, input int expEdges);
        int   edges;
        int   busyCycles;
        logic found;
        @(negedge clk);
        bus.a     = aVal;
        bus.b     = bVal;
        bus.op    = opVal;
        bus.start = 1'b1;
        @(posedge clk);
        edges      = 1;
        busyCycles = 0;
        found      = 1'b0;
        while (!found && edges < 64) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                edges++;
            end
        end
        checkOutput({tag, " done_seen"}, {31'd0, found}, 32'd1);
        checkOutput({tag, " result"}, bus.result, expRes);
        checkOutput({tag, " latency"}, 32'(edges), 32'(expEdges));
        checkOutput({tag, " busy_len"}, 32'(busyCycles), 32'(expEdges));
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " done_drop"}, {31'd0, bus.done}, 32'd0);
        checkOutput({tag, " idle_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int doneCount;
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;

        // Reset state, before any clock edge.
        #1;
        checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("1+1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, expLat(0, 0));
        applyStimulus("1-1", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, expLat(0, 0));
        applyStimulus("3+0.5", 32'h40400000, 32'h3F000000, 1'b0, 32'h40600000, expLat(2, 0));

        // Reset asserted while in ALIGN: outputs clear at once, no done follows.
        @(negedge clk);
        bus.a     = 32'h40400000;
        bus.b     = 32'h3F000000;
        bus.op    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("midrst busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst done", {31'd0, bus.done}, 32'd0);
        checkOutput("midrst result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) doneCount++;
        end
        checkOutput("midrst no_activity", 32'(doneCount), 32'd0);

        applyStimulus("post-rst 1+1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, expLat(0, 0));
        applyStimulus("1+2^-30", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, expLat(25, 0));
        applyStimulus("1.5-1", 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, expLat(0, 1));
        applyStimulus("1-2", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, expLat(1, 1));
        applyStimulus("0+3", 32'h00000000, 32'h40400000, 1'b0, 32'h40400000, expLat(25, 0));
        applyStimulus("1-2^-23", 32'h3F800000, 32'h34000000, 1'b1, 32'h3F7FFFFE, expLat(23, 1));
        applyStimulus("-1-1", 32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, expLat(0, 0));
        applyStimulus("ovf", 32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, expLat(0, 0));
        applyStimulus("flush", 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, expLat(0, 0));
        applyStimulus("2+2", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, expLat(0, 0));
        applyStimulus("tie 1+-1", 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, expLat(0, 0));

        // start held high: one operation per IDLE visit, DONE-cycle start ignored.
        @(negedge clk);
        bus.a     = 32'h3F800000;
        bus.b     = 32'h3F800000;
        bus.op    = 1'b0;
        bus.start = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) doneCount++;
            if (i == 4) checkOutput("held idle_gap", {31'd0, bus.busy}, 32'd0);
            if (i == 8) checkOutput("held second_done", {31'd0, bus.done}, 32'd1);
        end
        bus.start = 1'b0;
        checkOutput("held done_count", 32'(doneCount), 32'd4);
        checkOutput("held result", bus.result, 32'h40000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_addsub_ctrl.md
FP_ADDSUB_CTRL -- requirements
Module: fp_addsub_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 The block SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0=a+b, 1=a-b
- a  in  32  IEEE-754 single operand
- b  in  32  IEEE-754 single operand
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  32  packed sum/difference

Function
REQ-003 The state machine SHALL have exactly five states, IDLE, ALIGN, ADD, NORM and DONE, and SHALL sequence IDLE->ALIGN->ADD->NORM->DONE->IDLE.
REQ-004 In IDLE with start=1, the block SHALL latch a, b and op on the same edge, SHALL set the effective sign of b to b[31]^op, and SHALL enter ALIGN.
REQ-005 At capture, the block SHALL treat any operand with exponent 0 as zero, and its mantissa SHALL be {1'b0,23'b0}; otherwise the mantissa SHALL be {1'b1,frac}.
REQ-006 At capture, the larger-magnitude operand SHALL be chosen as L, comparing exponent first and then mantissa; on a tie, a SHALL be chosen; the other operand SHALL be S.
- Result exponent SHALL be initialised to exp(L).
- Alignment counter SHALL be loaded with min(exp(L)-exp(S), 25).
REQ-007 In ALIGN, if the counter is nonzero, the block SHALL shift S's mantissa right by 1 and decrement the counter; when the counter is 0, it SHALL go to ALIGN->ADD. ALIGN SHALL occupy counter+1 cycles.
REQ-008 ADD SHALL occupy exactly 1 cycle; the mantissa operation SHALL be as follows:
- Same effective signs: 25-bit add; on carry-out, shift the mantissa right by 1 and increment the exponent.
- Different signs: subtract L-S, never negative.
REQ-009 In NORM, each cycle the block SHALL go to NORM->DONE if mantissa[23]=1 or mantissa=0; otherwise it SHALL shift the mantissa left by 1 and decrement the exponent.
REQ-010 If normalisation would take the exponent to 0, the block SHALL flush the result to +0 and go to DONE.
REQ-011 result SHALL be packed as follows:
- Normal result: {sign(L), exp, mant[22:0]}.
- Zero mantissa: 0x00000000 (+0).
- Exponent reaching 255 after ADD: {sign, 8'hFF, 23'b0}.
REQ-012 Rounding SHALL be by truncation, with no guard, round or sticky bits. The block SHALL NOT detect NaN or infinity inputs; exponent 255 SHALL be arithmetic as normal.
REQ-013 done SHALL be 1 only in DONE; result SHALL update on entry to DONE and hold until the next DONE.
REQ-014 start SHALL be ignored while busy=1, with no queueing; start asserted in the DONE cycle SHALL also be ignored.
REQ-015 Minimum latency SHALL be 4 edges: start sampled at edge E0, with done=1 after edge E3 (diff=0, no normalise shift).

Reset
REQ-016 rst_n=0 SHALL immediately force the following, regardless of state, including mid-operation:
- state IDLE, busy=0, done=0, result=0x00000000;
- internal mantissas, exponent and counter to 0.
REQ-017 A partial operation SHALL be discarded on reset, and no done pulse SHALL be produced for it.

Configuration
REQ-018 The macro FP_ADDSUB_FAST_ALIGN_EN SHALL select the alignment implementation:
- Defined: ALIGN performs the full barrel right-shift by the counter value in a single cycle, so ALIGN lasts exactly 1 cycle.
- Undefined: iterative shift per REQ-007.
- Results SHALL be bit-identical in both builds.

Verification
REQ-019 a=0x3F800000, b=0x3F800000, op=0 -> result=0x40000000; done 4 edges after start; busy high 4 cycles.
REQ-020 a=0x3F800000, b=0x3F800000, op=1 -> result=0x00000000.
REQ-021 a=0x40400000 (3.0), b=0x3F000000 (0.5), op=0 -> result=0x40600000; done 6 edges after start (iterative) or 4 edges (FAST_ALIGN_EN).
REQ-022 a=0x3F800000, b=0x30800000 (2^-30), op=0 -> counter clamps at 25; result=0x3F800000.
REQ-023 a=0x3FC00000 (1.5), b=0x3F800000, op=1 -> NORM shifts 1; result=0x3F000000.
REQ-024 Reset and start handling:
- rst_n pulsed low during ALIGN -> busy=0 and result=0 immediately; no done; a new start afterwards completes normally.
- start held high throughout -> one op per IDLE visit.
